umi_packet_arbiter: RTL and testbench

- Packet-aware N:1 arbiter that shares one UMI request channel, typically the input of a width-converting UMI FIFO, between N requesters.
- Arbitration is round-robin or fixed-priority, selectable at run time.
- A grant is held from the first beat of a transaction until its EOM beat is accepted, so split or multi-beat transactions are never interleaved downstream.
- The datapath is combinational pass-through: zero added latency, no storage besides arbiter state.

---
 rtl/umi_pkg.sv | 29 ++
 rtl/umi_arb_rr.sv | 49 ++++
 rtl/umi_packet_arbiter.sv | 142 ++++++++++++++
 tb/tb_umi_packet_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : umi_pkg
// Description : Shared UMI definitions for the packet arbiter slice.
//               Command field offsets, arbiter mode encodings and the
//               arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package umi_pkg;

    // UMI command field offsets
    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_OPCODE_W   = 5;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_LEN_W      = 8;
    localparam int UMI_EOM_BIT    = 22;

    // Arbiter mode encodings (arb_mode input)
    localparam logic ARB_RR   = 1'b0;
    localparam logic ARB_PRIO = 1'b1;

    // Arbiter lock state
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage : umi_pkg
`default_nettype wire

// File: rtl/umi_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : umi_arb_rr
// Description : Combinational masked round-robin / fixed-priority picker.
//               Reusable for request and response channel arbitration.
// Ports       : req  - request vector (already masked by the caller)
//               ptr  - round-robin start index (ignored in priority mode)
//               mode - ARB_RR or ARB_PRIO
//               gnt  - one-hot grant, all zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module umi_arb_rr
    import umi_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt
);

    // One extra bit so ptr + k cannot overflow before the modulo-N wrap.
    logic [IW:0] w_idx;
    logic        w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (mode == ARB_PRIO) begin
                w_idx = (IW+1)'(k);
            end else begin
                w_idx = {1'b0, ptr} + (IW+1)'(k);
                if (w_idx >= (IW+1)'(N)) begin
                    w_idx = w_idx - (IW+1)'(N);
                end
            end
            if (!w_found && req[w_idx[IW-1:0]]) begin
                gnt[w_idx[IW-1:0]] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

endmodule : umi_arb_rr
`default_nettype wire

// File: rtl/umi_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : umi_packet_arbiter
// Description : Packet-aware N:1 arbiter for one UMI request channel.
//               A grant is held from the first beat of a transaction until
//               its EOM beat is accepted. Datapath is a zero-latency AND-OR
//               mux; the only storage is lock state, owner and rr pointer.
// Ports       : clk, nreset (async assert, active-low)
//               arb_mode / arb_mask     - arbitration policy and exclusions
//               umi_in_*  (packed xN)   - requester channels
//               umi_out_*               - merged downstream channel
//               arb_grant / arb_locked  - arbiter status
// Revision    : 1.0 - initial release
// ============================================================================
module umi_packet_arbiter
    import umi_pkg::*;
#(
    parameter int N      = 4,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 256,
    parameter int EOMBIT = UMI_EOM_BIT
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            arb_mode,
    input  logic [N-1:0]    arb_mask,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    arb_grant,
    output logic            arb_locked
);

    localparam int IW = $clog2(N);

    arb_state_t   r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;

    logic [N-1:0]  w_pick;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_gidx;
    logic [IW:0]   w_ptr_inc;
    logic [IW-1:0] w_ptr_next;
    logic          w_beat;
    logic          w_eom;

    umi_arb_rr #(
        .N    (N)
    ) u_pick (
        .req  (umi_in_valid & ~arb_mask),
        .ptr  (r_ptr),
        .mode (arb_mode),
        .gnt  (w_pick)
    );

    // Locked grant ignores mask/mode. Grant is also gated by nreset so the
    // whole channel goes quiet while reset is held, not just at the edge.
    always_comb begin
        if (!nreset) begin
            w_grant = '0;
        end else if (r_state == ST_LOCKED) begin
            w_grant = N'(1) << r_owner;
        end else begin
            w_grant = w_pick;
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | IW'(i);
            end
        end
    end

    // AND-OR mux: outputs are naturally zero when no requester is granted.
    always_comb begin
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi_out_cmd     = umi_out_cmd     | (umi_in_cmd[i*CW +: CW]     & {CW{w_grant[i]}});
            umi_out_dstaddr = umi_out_dstaddr | (umi_in_dstaddr[i*AW +: AW] & {AW{w_grant[i]}});
            umi_out_srcaddr = umi_out_srcaddr | (umi_in_srcaddr[i*AW +: AW] & {AW{w_grant[i]}});
            umi_out_data    = umi_out_data    | (umi_in_data[i*DW +: DW]    & {DW{w_grant[i]}});
        end
    end

    assign umi_out_valid = |(umi_in_valid & w_grant);
    assign umi_in_ready  = {N{umi_out_ready}} & w_grant;
    assign arb_grant     = w_grant;
    assign arb_locked    = (r_state == ST_LOCKED);

    assign w_beat = umi_out_valid & umi_out_ready;
    assign w_eom  = umi_out_cmd[EOMBIT];

    // Increment in IW+1 bits so the wrap compare works for any N (incl. N=2^k).
    assign w_ptr_inc  = {1'b0, w_gidx} + (IW+1)'(1);
    assign w_ptr_next = (w_ptr_inc >= (IW+1)'(N)) ? '0 : w_ptr_inc[IW-1:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Single-beat transactions never enter LOCKED.
                    if (w_beat && !w_eom) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_gidx;
                    end
                end
                ST_LOCKED: begin
                    if (w_beat && w_eom) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_beat && w_eom && (arb_mode == ARB_RR)) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule : umi_packet_arbiter
`default_nettype wire

// File: tb/tb_umi_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_packet_arbiter
// Description : Directed self-checking bench for umi_packet_arbiter (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_packet_arbiter;

    localparam int N      = 4;
    localparam int CW     = 32;
    localparam int AW     = 64;
    localparam int DW     = 256;
    localparam int EOMBIT = 22;

    logic            clk;
    logic            nreset;
    logic            arb_mode;
    logic [N-1:0]    arb_mask;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;
    logic [N-1:0]    arb_grant;
    logic            arb_locked;

    int errors;
    int checks;
    int cnt [N];

    umi_packet_arbiter #(
        .N      (N),
        .CW     (CW),
        .AW     (AW),
        .DW     (DW),
        .EOMBIT (EOMBIT)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .arb_mode        (arb_mode),
        .arb_mask        (arb_mask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .arb_grant       (arb_grant),
        .arb_locked      (arb_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] exp_cmd(input int i, input logic eom);
        logic [CW-1:0] c;
        c         = '0;
        c[7:0]    = 8'(i + 1);
        c[31:24]  = 8'hA5;
        c[EOMBIT] = eom;
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int i);
        logic [DW-1:0] d;
        d          = '0;
        d[7:0]     = 8'(i);
        d[255:248] = 8'hDA;
        return d;
    endfunction

    task automatic set_req(input int i, input logic v, input logic eom);
        umi_in_valid[i]              = v;
        umi_in_cmd[i*CW +: CW]       = exp_cmd(i, eom);
        umi_in_dstaddr[i*AW +: AW]   = 64'hD000_0000_0000_0000 | 64'(i);
        umi_in_srcaddr[i*AW +: AW]   = 64'h5000_0000_0000_0000 | 64'(i);
        umi_in_data[i*DW +: DW]      = exp_data(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        nreset         = 1'b0;
        arb_mode       = 1'b0;
        arb_mask       = '0;
        umi_out_ready  = 1'b1;
        umi_in_valid   = '0;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1);

        // Reset: everything quiet even with all requesters valid
        step();
        step();
        check("rst_grant",  256'(arb_grant), 256'(4'b0000));
        check("rst_valid",  256'(umi_out_valid), 256'(1'b0));
        check("rst_ready",  256'(umi_in_ready), 256'(4'b0000));
        check("rst_locked", 256'(arb_locked), 256'(1'b0));
        check("rst_cmd",    256'(umi_out_cmd), 256'(32'h0));
        check("rst_data",   umi_out_data, 256'h0);

        // 1. Round-robin rotation and fairness, single-beat transactions
        nreset = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_grant%0d", k), 256'(arb_grant), 256'(4'b0001 << (k % 4)));
            step();
        end
        for (int j = 0; j < N; j++) cnt[j] = 0;
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < N; j++) if (arb_grant[j]) cnt[j]++;
            step();
        end
        for (int j = 0; j < N; j++) check($sformatf("rr_share%0d", j), 256'(cnt[j]), 256'(100));
        check("rr_never_locked", 256'(arb_locked), 256'(1'b0));

        // 2. Lock: req1 sends 3 beats while req0/req2 are valid
        set_req(3, 1'b0, 1'b1);
        #1;
        check("lk_pre_grant", 256'(arb_grant), 256'(4'b0001));
        step();                                   // req0 EOM beat -> ptr=1
        set_req(1, 1'b1, 1'b0);
        #1;
        check("lk_b1_grant",  256'(arb_grant), 256'(4'b0010));
        check("lk_b1_cmd",    256'(umi_out_cmd), 256'(exp_cmd(1, 1'b0)));
        check("lk_b1_locked", 256'(arb_locked), 256'(1'b0));
        check("lk_b1_ready",  256'(umi_in_ready), 256'(4'b0010));
        step();
        check("lk_b2_grant",  256'(arb_grant), 256'(4'b0010));
        check("lk_b2_locked", 256'(arb_locked), 256'(1'b1));
        step();
        set_req(1, 1'b1, 1'b1);
        #1;
        check("lk_b3_grant",  256'(arb_grant), 256'(4'b0010));
        check("lk_b3_locked", 256'(arb_locked), 256'(1'b1));
        step();
        check("lk_next_grant",  256'(arb_grant), 256'(4'b0100));
        check("lk_next_locked", 256'(arb_locked), 256'(1'b0));

        // 3. Backpressure mid-lock (owner 2)
        set_req(2, 1'b1, 1'b0);
        step();                                   // first beat of req2 -> LOCKED
        umi_out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_locked%0d", k), 256'(arb_locked), 256'(1'b1));
            check($sformatf("bp_grant%0d", k),  256'(arb_grant), 256'(4'b0100));
            check($sformatf("bp_ready%0d", k),  256'(umi_in_ready), 256'(4'b0000));
            check($sformatf("bp_cmd%0d", k),    256'(umi_out_cmd), 256'(exp_cmd(2, 1'b0)));
            check($sformatf("bp_dst%0d", k),    256'(umi_out_dstaddr), 256'(64'hD000_0000_0000_0002));
            check($sformatf("bp_data%0d", k),   umi_out_data, exp_data(2));
            step();
        end

        // 5. Owner bubble: owner 2 drops valid for 2 cycles
        umi_out_ready = 1'b1;
        set_req(2, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bub_valid%0d", k), 256'(umi_out_valid), 256'(1'b0));
            check($sformatf("bub_grant%0d", k), 256'(arb_grant), 256'(4'b0100));
            check($sformatf("bub_ready%0d", k), 256'(umi_in_ready), 256'(4'b0100));
            step();
        end
        set_req(2, 1'b1, 1'b1);
        #1;
        check("bub_eom_valid", 256'(umi_out_valid), 256'(1'b1));
        step();                                   // EOM from req2 -> ptr=3
        set_req(2, 1'b0, 1'b1);
        #1;
        check("bub_after_grant", 256'(arb_grant), 256'(4'b0001));

        // 4. Fixed priority and mask
        arb_mode = 1'b1;
        set_req(0, 1'b0, 1'b1);
        set_req(3, 1'b1, 1'b1);
        #1;
        check("pr_grant", 256'(arb_grant), 256'(4'b0010));
        arb_mask = 4'b0010;
        #1;
        check("pr_mask_grant", 256'(arb_grant), 256'(4'b1000));
        arb_mask = 4'b0000;
        set_req(1, 1'b1, 1'b0);
        #1;
        check("pr_lock_grant", 256'(arb_grant), 256'(4'b0010));
        step();                                   // req1 locks
        arb_mask = 4'b0010;
        #1;
        check("pr_mlock_grant",  256'(arb_grant), 256'(4'b0010));
        check("pr_mlock_locked", 256'(arb_locked), 256'(1'b1));
        check("pr_mlock_ready",  256'(umi_in_ready), 256'(4'b0010));
        set_req(1, 1'b1, 1'b1);
        step();                                   // EOM in priority mode: ptr stays 3
        check("pr_post_grant", 256'(arb_grant), 256'(4'b1000));
        arb_mode = 1'b0;
        arb_mask = 4'b0000;
        set_req(3, 1'b0, 1'b1);
        set_req(2, 1'b1, 1'b1);
        #1;
        check("pr_ptr_kept", 256'(arb_grant), 256'(4'b0010));

        // 6. Async reset mid-lock
        set_req(1, 1'b1, 1'b0);
        step();                                   // req1 locks
        check("ar_locked_pre", 256'(arb_locked), 256'(1'b1));
        #2;
        nreset = 1'b0;
        #1;
        check("ar_valid",  256'(umi_out_valid), 256'(1'b0));
        check("ar_grant",  256'(arb_grant), 256'(4'b0000));
        check("ar_locked", 256'(arb_locked), 256'(1'b0));
        check("ar_ready",  256'(umi_in_ready), 256'(4'b0000));
        step();
        nreset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1);
        #1;
        check("ar_rel_grant",  256'(arb_grant), 256'(4'b0001));
        check("ar_rel_locked", 256'(arb_locked), 256'(1'b0));
        step();
        check("ar_rel_grant2", 256'(arb_grant), 256'(4'b0010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_umi_packet_arbiter
`default_nettype wire
